// File: rtl/lsb_param_if.sv
// Request/response bus between the load/store buffer and the memory controller.
// The buffer side (master) drives a request and holds it until the controller
// (slave) returns a one-cycle done pulse, together with raw load data.
interface lsb_param_if;
    logic        todo;
    logic [31:0] addr;
    logic [2:0]  len;
    logic        store;
    logic [31:0] store_data;
    logic [31:0] load_res;
    logic        done;

    modport master (
        output todo, addr, len, store, store_data,
        input  load_res, done
    );

    modport slave (
        input  todo, addr, len, store, store_data,
        output load_res, done
    );
endinterface

// File: rtl/lsb_param.sv
// Parametrised in-order load/store buffer.
// Entries are allocated at the tail, wake up from the ALU and load CDB
// channels, and issue strictly from the head, one memory request at a time.
// Stores issue only once the ROB has committed them; loads issue
// speculatively. A mispredict flush keeps the committed stores (and a load
// that is already talking to memory, whose result is then suppressed).
module lsb_param #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             io_buffer_full,
    input  logic             flush,
    output logic             lsb_full,
    input  logic             lsb_todo,
    input  logic [5:0]       lsb_inst_type,
    input  logic [ROB_W-1:0] lsb_rs1_rob_pos,
    input  logic [ROB_W-1:0] lsb_rs2_rob_pos,
    input  logic [31:0]      lsb_val1,
    input  logic [31:0]      lsb_val2,
    input  logic [31:0]      lsb_imm,
    input  logic [ROB_W-1:0] lsb_rd_rob_pos,
    input  logic             alu_done,
    input  logic [31:0]      alu_res,
    input  logic [ROB_W-1:0] alu_rob_pos,
    input  logic             store_todo,
    lsb_param_if.master      memctrl,
    output logic             load_done,
    output logic [31:0]      load_res,
    output logic [ROB_W-1:0] load_rob_pos
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ROB_W-1:0] NONE     = {ROB_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    localparam logic [5:0] T_LB  = 6'd10;
    localparam logic [5:0] T_LH  = 6'd11;
    localparam logic [5:0] T_LBU = 6'd13;
    localparam logic [5:0] T_LHU = 6'd14;
    localparam logic [5:0] T_SB  = 6'd15;
    localparam logic [5:0] T_SH  = 6'd16;
    localparam logic [5:0] T_SW  = 6'd17;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

    // Store opcodes occupy a contiguous range.
    function automatic logic is_store_f(input logic [5:0] t);
        return (t >= T_SB) && (t <= T_SW);
    endfunction

    // Access length in bytes for an opcode.
    function automatic logic [2:0] len_f(input logic [5:0] t);
        logic [2:0] l;
        case (t)
            T_LB, T_LBU, T_SB: l = 3'd1;
            T_LH, T_LHU, T_SH: l = 3'd2;
            default:           l = 3'd4;
        endcase
        return l;
    endfunction

    // Sign/zero extension of raw load data according to the load opcode.
    function automatic logic [31:0] ext_f(input logic [5:0] t, input logic [31:0] raw);
        logic [31:0] r;
        case (t)
            T_LB:    r = {{24{raw[7]}}, raw[7:0]};
            T_LBU:   r = {24'd0, raw[7:0]};
            T_LH:    r = {{16{raw[15]}}, raw[15:0]};
            T_LHU:   r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Operand capture: returns {tag, value}; a pending tag matching either
    // broadcast channel becomes ready (NONE) with the broadcast value.
    function automatic logic [ROB_W+31:0] wake_f(
        input logic [ROB_W-1:0] tag,   input logic [31:0] val,
        input logic             a_v,   input logic [ROB_W-1:0] a_tag, input logic [31:0] a_val,
        input logic             l_v,   input logic [ROB_W-1:0] l_tag, input logic [31:0] l_val
    );
        logic [ROB_W+31:0] r;
        if (tag != NONE && a_v && tag == a_tag) begin
            r = {NONE, a_val};
        end else if (tag != NONE && l_v && tag == l_tag) begin
            r = {NONE, l_val};
        end else begin
            r = {tag, val};
        end
        return r;
    endfunction

    // Entry storage
    logic             ent_valid_r [DEPTH];
    logic             ent_comm_r  [DEPTH];
    logic [5:0]       ent_type_r  [DEPTH];
    logic [ROB_W-1:0] ent_rs1_r   [DEPTH];
    logic [ROB_W-1:0] ent_rs2_r   [DEPTH];
    logic [ROB_W-1:0] ent_rd_r    [DEPTH];
    logic [31:0]      ent_val1_r  [DEPTH];
    logic [31:0]      ent_val2_r  [DEPTH];
    logic [31:0]      ent_imm_r   [DEPTH];

    logic [PTR_W-1:0] head_r, tail_r, head_n_s, tail_n_s, commit_idx_s;
    logic [PTR_W:0]   count_r, ccnt_r, count_n_s, ccnt_n_s;
    state_t           state_r, state_n_s;
    logic             discard_r;

    logic             mem_todo_r, mem_store_r;
    logic [31:0]      mem_addr_r, mem_data_r;
    logic [2:0]       mem_len_r;
    logic [5:0]       pend_type_r;
    logic [ROB_W-1:0] pend_rd_r;

    logic             load_done_r;
    logic [31:0]      load_res_r;
    logic [ROB_W-1:0] load_rob_r;

    logic             head_is_store_s, head_ready_s, io_block_s;
    logic [31:0]      head_addr_s;
    logic             issue_s, pop_s, alloc_s, commit_s, keep_s;
    logic [ROB_W-1:0] alloc_rs1_s, alloc_rs2_s;
    logic [31:0]      alloc_val1_s, alloc_val2_s;

    assign lsb_full              = (count_r == CNT_FULL);
    assign memctrl.todo          = mem_todo_r;
    assign memctrl.addr          = mem_addr_r;
    assign memctrl.len           = mem_len_r;
    assign memctrl.store         = mem_store_r;
    assign memctrl.store_data    = mem_data_r;
    assign load_done             = load_done_r;
    assign load_res              = load_res_r;
    assign load_rob_pos          = load_rob_r;

    // Head-entry readiness and IO back-pressure decode.
    always_comb begin
        head_is_store_s = is_store_f(ent_type_r[head_r]);
        head_addr_s     = ent_val1_r[head_r] + ent_imm_r[head_r];
        io_block_s      = io_buffer_full && (head_addr_s[17:16] == 2'b11);
        if (head_is_store_s) begin
            head_ready_s = ent_valid_r[head_r] && (ent_rs1_r[head_r] == NONE) &&
                           (ent_rs2_r[head_r] == NONE) && ent_comm_r[head_r];
        end else begin
            head_ready_s = ent_valid_r[head_r] && (ent_rs1_r[head_r] == NONE);
        end
    end

    // Request FSM next state: IDLE issues the head, PENDING waits for done.
    always_comb begin
        state_n_s = state_r;
        issue_s   = 1'b0;
        pop_s     = 1'b0;
        if (rdy_in) begin
            case (state_r)
                S_IDLE: begin
                    if (!flush && head_ready_s && !io_block_s) begin
                        issue_s   = 1'b1;
                        state_n_s = S_PENDING;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                S_PENDING: begin
                    if (memctrl.done) begin
                        pop_s     = 1'b1;
                        state_n_s = S_IDLE;
                    end else begin
                        state_n_s = S_PENDING;
                    end
                end
                default: state_n_s = S_IDLE;
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Allocation, commit and same-cycle operand bypass for the incoming entry.
    always_comb begin
        alloc_s      = rdy_in && lsb_todo && !flush && (!lsb_full || pop_s);
        commit_s     = rdy_in && store_todo;
        commit_idx_s = head_r + ccnt_r[PTR_W-1:0];
        // An in-flight load survives a flush until memory answers.
        keep_s       = (state_r == S_PENDING) && !mem_store_r && !pop_s;
        {alloc_rs1_s, alloc_val1_s} = wake_f(lsb_rs1_rob_pos, lsb_val1, alu_done, alu_rob_pos,
                                             alu_res, load_done_r, load_rob_r, load_res_r);
        {alloc_rs2_s, alloc_val2_s} = wake_f(lsb_rs2_rob_pos, lsb_val2, alu_done, alu_rob_pos,
                                             alu_res, load_done_r, load_rob_r, load_res_r);
    end

    // Pointer and counter next state, including flush rewind to the committed stores.
    always_comb begin
        head_n_s  = head_r;
        tail_n_s  = tail_r;
        count_n_s = count_r;
        ccnt_n_s  = ccnt_r;
        if (pop_s) begin
            head_n_s = head_r + PTR_ONE;
        end else begin
            head_n_s = head_r;
        end
        case ({commit_s, pop_s && mem_store_r})
            2'b10:   ccnt_n_s = ccnt_r + CNT_ONE;
            2'b01:   ccnt_n_s = ccnt_r - CNT_ONE;
            default: ccnt_n_s = ccnt_r;
        endcase
        if (rdy_in && flush) begin
            tail_n_s  = head_n_s + ccnt_n_s[PTR_W-1:0] + (keep_s ? PTR_ONE : PTR_ZERO);
            count_n_s = ccnt_n_s + (keep_s ? CNT_ONE : {(PTR_W+1){1'b0}});
        end else begin
            if (alloc_s) begin
                tail_n_s = tail_r + PTR_ONE;
            end else begin
                tail_n_s = tail_r;
            end
            case ({alloc_s, pop_s})
                2'b10:   count_n_s = count_r + CNT_ONE;
                2'b01:   count_n_s = count_r - CNT_ONE;
                default: count_n_s = count_r;
            endcase
        end
    end

    // FSM state, pointers and counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= S_IDLE;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            ccnt_r  <= '0;
        end else if (rdy_in) begin
            state_r <= state_n_s;
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
            ccnt_r  <= ccnt_n_s;
        end
    end

    // Entry array: wakeup, commit, flush, pop, then allocation last so a
    // pop+push on the same slot at full keeps the new entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_r[i] <= 1'b0;
                ent_comm_r[i]  <= 1'b0;
                ent_type_r[i]  <= 6'd0;
                ent_rs1_r[i]   <= NONE;
                ent_rs2_r[i]   <= NONE;
                ent_rd_r[i]    <= '0;
                ent_val1_r[i]  <= 32'd0;
                ent_val2_r[i]  <= 32'd0;
                ent_imm_r[i]   <= 32'd0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid_r[i]) begin
                    {ent_rs1_r[i], ent_val1_r[i]} <= wake_f(ent_rs1_r[i], ent_val1_r[i], alu_done,
                        alu_rob_pos, alu_res, load_done_r, load_rob_r, load_res_r);
                    {ent_rs2_r[i], ent_val2_r[i]} <= wake_f(ent_rs2_r[i], ent_val2_r[i], alu_done,
                        alu_rob_pos, alu_res, load_done_r, load_rob_r, load_res_r);
                end
                if (flush && !ent_comm_r[i] && !(commit_s && commit_idx_s == PTR_W'(i)) &&
                    !(keep_s && head_r == PTR_W'(i))) begin
                    ent_valid_r[i] <= 1'b0;
                end
            end
            if (commit_s) begin
                ent_comm_r[commit_idx_s] <= 1'b1;
            end
            if (pop_s) begin
                ent_valid_r[head_r] <= 1'b0;
            end
            if (alloc_s) begin
                ent_valid_r[tail_r] <= 1'b1;
                ent_comm_r[tail_r]  <= 1'b0;
                ent_type_r[tail_r]  <= lsb_inst_type;
                ent_rs1_r[tail_r]   <= alloc_rs1_s;
                ent_rs2_r[tail_r]   <= alloc_rs2_s;
                ent_val1_r[tail_r]  <= alloc_val1_s;
                ent_val2_r[tail_r]  <= alloc_val2_s;
                ent_imm_r[tail_r]   <= lsb_imm;
                ent_rd_r[tail_r]    <= lsb_rd_rob_pos;
            end
        end
    end

    // Memory request registers: captured on issue, held until done.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_todo_r  <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_len_r   <= 3'd0;
            mem_store_r <= 1'b0;
            mem_data_r  <= 32'd0;
            pend_type_r <= 6'd0;
            pend_rd_r   <= '0;
        end else if (rdy_in) begin
            if (issue_s) begin
                mem_todo_r  <= 1'b1;
                mem_addr_r  <= head_addr_s;
                mem_len_r   <= len_f(ent_type_r[head_r]);
                mem_store_r <= head_is_store_s;
                mem_data_r  <= ent_val2_r[head_r];
                pend_type_r <= ent_type_r[head_r];
                pend_rd_r   <= ent_rd_r[head_r];
            end else if (pop_s) begin
                mem_todo_r  <= 1'b0;
            end
        end
    end

    // Discard flag: a flushed in-flight load must not broadcast its result.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            discard_r <= 1'b0;
        end else if (rdy_in) begin
            if (pop_s) begin
                discard_r <= 1'b0;
            end else if (flush && state_r == S_PENDING && !mem_store_r) begin
                discard_r <= 1'b1;
            end
        end
    end

    // Load CDB broadcast: one-cycle pulse after a surviving load completes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            load_done_r <= 1'b0;
            load_res_r  <= 32'd0;
            load_rob_r  <= '0;
        end else if (rdy_in) begin
            load_done_r <= 1'b0;
            if (pop_s && !mem_store_r && !discard_r && !flush) begin
                load_done_r <= 1'b1;
                load_rob_r  <= pend_rd_r;
                load_res_r  <= ext_f(pend_type_r, memctrl.load_res);
            end
        end
    end
endmodule

// File: tb/tb_lsb_param.sv
// Directed bench for lsb_param: the bench acts as dispatcher, ROB, ALU CDB and
// memory controller, and compares outputs against hand-computed values.
module tb_lsb_param;
    localparam int DEPTH = 16;
    localparam int ROB_W = 5;
    localparam logic [ROB_W-1:0] NONE = 5'h1F;
    localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13, LHU = 6'd14;
    localparam logic [5:0] SB = 6'd15, SW = 6'd17;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, io_buffer_full, flush, lsb_full, lsb_todo;
    logic [5:0]       lsb_inst_type;
    logic [ROB_W-1:0] lsb_rs1_rob_pos, lsb_rs2_rob_pos, lsb_rd_rob_pos, alu_rob_pos, load_rob_pos;
    logic [31:0]      lsb_val1, lsb_val2, lsb_imm, alu_res, load_res;
    logic             alu_done, store_todo, load_done;

    int tests_run    = 0;
    int tests_failed = 0;

    lsb_param_if mem_if ();

    lsb_param #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .io_buffer_full(io_buffer_full), .flush(flush), .lsb_full(lsb_full),
        .lsb_todo(lsb_todo), .lsb_inst_type(lsb_inst_type),
        .lsb_rs1_rob_pos(lsb_rs1_rob_pos), .lsb_rs2_rob_pos(lsb_rs2_rob_pos),
        .lsb_val1(lsb_val1), .lsb_val2(lsb_val2), .lsb_imm(lsb_imm),
        .lsb_rd_rob_pos(lsb_rd_rob_pos), .alu_done(alu_done), .alu_res(alu_res),
        .alu_rob_pos(alu_rob_pos), .store_todo(store_todo), .memctrl(mem_if),
        .load_done(load_done), .load_res(load_res), .load_rob_pos(load_rob_pos)
    );

    always #5 clk_in = ~clk_in;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic alloc(input logic [5:0] ty, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [4:0] rd);
        lsb_todo = 1'b1; lsb_inst_type = ty; lsb_rs1_rob_pos = r1; lsb_rs2_rob_pos = r2;
        lsb_val1 = v1; lsb_val2 = v2; lsb_imm = imm; lsb_rd_rob_pos = rd;
        tick();
        lsb_todo = 1'b0;
    endtask

    task automatic complete(input logic [31:0] res);
        mem_if.done = 1'b1; mem_if.load_res = res;
        tick();
        mem_if.done = 1'b0; mem_if.load_res = 32'd0;
    endtask

    task automatic wait_req(input string tag);
        for (int c = 0; c < 8 && !mem_if.todo; c++) tick();
        chk_val(tag, 32'(mem_if.todo), 32'd1);
    endtask

    initial begin
        logic [5:0]  ty;
        logic [31:0] raw, expv;
        logic [2:0]  ln;
        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        lsb_todo = 1'b0; lsb_inst_type = 6'd0; lsb_rs1_rob_pos = NONE; lsb_rs2_rob_pos = NONE;
        lsb_val1 = 32'd0; lsb_val2 = 32'd0; lsb_imm = 32'd0; lsb_rd_rob_pos = 5'd0;
        alu_done = 1'b0; alu_res = 32'd0; alu_rob_pos = 5'd0; store_todo = 1'b0;
        mem_if.done = 1'b0; mem_if.load_res = 32'd0;
        repeat (3) tick();
        chk_val("rst_todo", 32'(mem_if.todo), 32'd0);
        chk_val("rst_addr", mem_if.addr, 32'd0);
        chk_val("rst_len", 32'(mem_if.len), 32'd0);
        chk_val("rst_data", mem_if.store_data, 32'd0);
        chk_val("rst_ld", 32'(load_done), 32'd0);
        chk_val("rst_full", 32'(lsb_full), 32'd0);
        rst_in = 1'b1;
        tick();

        // 1: LW, exact latency and CDB result
        alloc(LW, NONE, NONE, 32'h100, 32'd0, 32'h4, 5'd3);
        chk_val("t1_lat0", 32'(mem_if.todo), 32'd0);
        tick();
        chk_val("t1_todo", 32'(mem_if.todo), 32'd1);
        chk_val("t1_addr", mem_if.addr, 32'h104);
        chk_val("t1_len", 32'(mem_if.len), 32'd4);
        chk_val("t1_store", 32'(mem_if.store), 32'd0);
        tick();
        chk_val("t1_hold", mem_if.addr, 32'h104);
        complete(32'hDEADBEEF);
        chk_val("t1_ld", 32'(load_done), 32'd1);
        chk_val("t1_res", load_res, 32'hDEADBEEF);
        chk_val("t1_rob", 32'(load_rob_pos), 32'd3);
        chk_val("t1_todo_clr", 32'(mem_if.todo), 32'd0);
        tick();
        chk_val("t1_ld_clr", 32'(load_done), 32'd0);

        // 2: sub-word load extension
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin ty = LB;  raw = 32'h000000F0; expv = 32'hFFFFFFF0; ln = 3'd1; end
                1:       begin ty = LBU; raw = 32'h000000F0; expv = 32'h000000F0; ln = 3'd1; end
                2:       begin ty = LH;  raw = 32'h00008001; expv = 32'hFFFF8001; ln = 3'd2; end
                default: begin ty = LHU; raw = 32'h00008001; expv = 32'h00008001; ln = 3'd2; end
            endcase
            alloc(ty, NONE, NONE, 32'h200, 32'd0, 32'd0, 5'd4);
            tick();
            chk_val("t2_len", 32'(mem_if.len), 32'(ln));
            complete(raw);
            chk_val("t2_res", load_res, expv);
        end

        // 3: store waits for data and commit
        alloc(SW, NONE, 5'd7, 32'h200, 32'd0, 32'd0, 5'd8);
        repeat (2) tick();
        chk_val("t3_wait_data", 32'(mem_if.todo), 32'd0);
        alu_done = 1'b1; alu_rob_pos = 5'd7; alu_res = 32'h55;
        tick();
        alu_done = 1'b0;
        tick();
        chk_val("t3_wait_commit", 32'(mem_if.todo), 32'd0);
        store_todo = 1'b1;
        tick();
        store_todo = 1'b0;
        chk_val("t3_commit_lat", 32'(mem_if.todo), 32'd0);
        tick();
        chk_val("t3_todo", 32'(mem_if.todo), 32'd1);
        chk_val("t3_store", 32'(mem_if.store), 32'd1);
        chk_val("t3_data", mem_if.store_data, 32'h55);
        chk_val("t3_len", 32'(mem_if.len), 32'd4);
        complete(32'd0);
        chk_val("t3_no_ld", 32'(load_done), 32'd0);

        // 4: allocation bypass from same-cycle ALU broadcast
        alu_done = 1'b1; alu_rob_pos = 5'd12; alu_res = 32'h1000;
        alloc(LW, 5'd12, NONE, 32'hBAD0, 32'd0, 32'h8, 5'd2);
        alu_done = 1'b0;
        tick();
        chk_val("t4_todo", 32'(mem_if.todo), 32'd1);
        chk_val("t4_addr", mem_if.addr, 32'h1008);
        complete(32'h1234);
        chk_val("t4_res", load_res, 32'h1234);
        chk_val("t4_rob", 32'(load_rob_pos), 32'd2);

        // 5: fill, full push ignored, pop+push at full, wrap-around drain
        alloc(LW, NONE, NONE, 32'h4000, 32'd0, 32'd0, 5'd1);
        for (int k = 1; k < DEPTH; k++) begin
            alloc(LW, 5'd9, NONE, 32'd0, 32'd0, 32'(4 * k), 5'd1);
            if (k == DEPTH - 2) chk_val("t5_not_full", 32'(lsb_full), 32'd0);
        end
        chk_val("t5_full", 32'(lsb_full), 32'd1);
        chk_val("t5_head_addr", mem_if.addr, 32'h4000);
        alloc(LW, 5'd9, NONE, 32'd0, 32'd0, 32'h999, 5'd1);
        mem_if.done = 1'b1; mem_if.load_res = 32'd0;
        alloc(LW, 5'd9, NONE, 32'd0, 32'd0, 32'(4 * DEPTH), 5'd1);
        mem_if.done = 1'b0;
        chk_val("t5_popush_full", 32'(lsb_full), 32'd1);
        chk_val("t5_popush_ld", 32'(load_done), 32'd1);
        alu_done = 1'b1; alu_rob_pos = 5'd9; alu_res = 32'h4000;
        tick();
        alu_done = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            wait_req("t5_req");
            chk_val("t5_drain_addr", mem_if.addr, 32'h4000 + 32'(4 * k));
            complete(32'd0);
        end
        repeat (3) tick();
        chk_val("t5_empty_todo", 32'(mem_if.todo), 32'd0);
        chk_val("t5_empty_full", 32'(lsb_full), 32'd0);

        // 6a: flush with a load in flight -> result suppressed
        alloc(LW, NONE, NONE, 32'h300, 32'd0, 32'd0, 5'd5);
        alloc(LW, NONE, NONE, 32'h304, 32'd0, 32'd0, 5'd6);
        chk_val("t6_inflight", mem_if.addr, 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_val("t6_req_kept", 32'(mem_if.todo), 32'd1);
        complete(32'h77);
        chk_val("t6_discard", 32'(load_done), 32'd0);
        repeat (3) tick();
        chk_val("t6_flushed", 32'(mem_if.todo), 32'd0);

        // 6b: committed SB survives flush, held by IO back-pressure
        io_buffer_full = 1'b1;
        alloc(SB, NONE, NONE, 32'h30000, 32'hAB, 32'd0, 5'd10);
        store_todo = 1'b1;
        tick();
        store_todo = 1'b0;
        alloc(LW, NONE, NONE, 32'h400, 32'd0, 32'd0, 5'd11);
        alloc(LW, NONE, NONE, 32'h404, 32'd0, 32'd0, 5'd12);
        repeat (2) tick();
        chk_val("t6_io_hold", 32'(mem_if.todo), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk_val("t6_io_hold2", 32'(mem_if.todo), 32'd0);
        io_buffer_full = 1'b0;
        tick();
        chk_val("t6_sb_todo", 32'(mem_if.todo), 32'd1);
        chk_val("t6_sb_store", 32'(mem_if.store), 32'd1);
        chk_val("t6_sb_addr", mem_if.addr, 32'h30000);
        chk_val("t6_sb_len", 32'(mem_if.len), 32'd1);
        chk_val("t6_sb_data", mem_if.store_data, 32'hAB);
        complete(32'd0);
        repeat (3) tick();
        chk_val("t6_loads_gone", 32'(mem_if.todo), 32'd0);
        for (int k = 0; k < DEPTH - 1; k++) alloc(LW, 5'd9, NONE, 32'd0, 32'd0, 32'd0, 5'd1);
        chk_val("t6_cnt_below", 32'(lsb_full), 32'd0);
        alloc(LW, 5'd9, NONE, 32'd0, 32'd0, 32'd0, 5'd1);
        chk_val("t6_cnt_full", 32'(lsb_full), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
